// File: rtl/instr_encoder.sv
// RV32I instruction word encoder with a DEPTH-entry output FIFO and a count of words handed out.
// Optional macro RANGE_CHECK_EN flags immediates that the selected format cannot represent.
module instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_f3,
  input  logic [6:0]       in_f7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;
  localparam logic [2:0] FMT_R = 3'b101;

  logic [31:0]   mem_instr [DEPTH];
  logic          mem_err   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [31:0]   enc_word;
  logic          enc_err;
  logic          range_bad;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid never waits on ready, and in_ready depends only on registered occupancy.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = mem_instr[rd_ptr];
  assign out_err   = mem_err[rd_ptr];

  always_comb begin
    enc_word = 32'h0000_0013;
    enc_err  = 1'b0;
    unique case (in_fmt)
      FMT_I: enc_word = {in_imm[11:0], in_rs1, in_f3, in_rd, in_op};
      FMT_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_f3, in_imm[4:0], in_op};
      FMT_B: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_f3,
                         in_imm[4:1], in_imm[11], in_op};
      FMT_J: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
      FMT_U: enc_word = {in_imm[31:12], in_rd, in_op};
      FMT_R: enc_word = {in_f7, in_rs2, in_rs1, in_f3, in_rd, in_op};
      default: begin
        enc_word = 32'h0000_0013;
        enc_err  = 1'b1;
      end
    endcase
    enc_err = enc_err | range_bad;
  end

`ifdef RANGE_CHECK_EN
  // The word is still produced by truncation; only the flag reports the lost bits.
  always_comb begin
    range_bad = 1'b0;
    unique case (in_fmt)
      FMT_I, FMT_S: range_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      FMT_B:        range_bad = in_imm[0] || !((&in_imm[31:12]) || !(|in_imm[31:12]));
      FMT_J:        range_bad = in_imm[0] || !((&in_imm[31:20]) || !(|in_imm[31:20]));
      FMT_U:        range_bad = (in_imm[11:0] != 12'h000);
      default:      range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= 32'h0;
        mem_err[i]   <= 1'b0;
      end
    end else if (push) begin
      mem_instr[wr_ptr] <= enc_word;
      mem_err[wr_ptr]   <= enc_err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      enc_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        enc_count <= enc_count + CNT_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
